// File: rtl/motor_throttle_sequencer_if.sv
// Throttle command channel: one valid/ready transfer carries a channel number and a requested duty.
interface motor_throttle_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_ch;
  logic [7:0] cmd_duty;

  modport master (output cmd_valid, output cmd_ch, output cmd_duty, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_ch, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_throttle_sequencer.sv
// Four-channel ESC throttle sequencer: shared PWM period counter, arming FSM and slew-limited
// duty updates applied only at period boundaries; commands accepted one per cycle while in RUN.
module motor_throttle_sequencer #(
  parameter int PERIOD      = 100,
  parameter int DUTY_MAX    = 100,
  parameter int SLEW        = 10,
  parameter int ARM_PERIODS = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic                      arm,
  motor_throttle_sequencer_if.slave cmd,
  output logic [3:0]                pwm_out,
  output logic                      period_start,
  output logic                      armed,
  output logic [1:0]                state,
  output logic [31:0]               duty_mon
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMING   = 2'd1,
    RUN      = 2'd2,
    RAMPDOWN = 2'd3
  } state_e;

  localparam int ACW = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;
  localparam logic [7:0]     LAST_CNT  = 8'(PERIOD - 1);
  localparam logic [7:0]     DUTY_CEIL = 8'(DUTY_MAX);
  localparam logic [7:0]     SLEW_STEP = 8'(SLEW);
  localparam logic [ACW-1:0] ARM_LAST  = ACW'(ARM_PERIODS - 1);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACW-1:0]   arm_cnt_q, arm_cnt_d;
  logic [3:0][7:0]  target_q, target_d;
  logic [3:0][7:0]  applied_q, applied_d;
  logic [3:0]       pwm_q, pwm_d;
  logic             period_start_q, period_start_d;
  logic             armed_q, armed_d;
  logic             boundary;
  logic             accept;
  logic [7:0]       cmd_sat;

  function automatic logic [7:0] slew_toward(input logic [7:0] cur, input logic [7:0] tgt);
    logic [7:0] gap;
    gap = (tgt > cur) ? (tgt - cur) : (cur - tgt);
    if (gap > SLEW_STEP) gap = SLEW_STEP;
    return (tgt > cur) ? (cur + gap) : (cur - gap);
  endfunction

  assign cmd.cmd_ready = (state_q == RUN);
  assign pwm_out       = pwm_q;
  assign period_start  = period_start_q;
  assign armed         = armed_q;
  assign state         = state_q;
  assign duty_mon      = applied_q;

  always_comb begin
    boundary       = (cnt_q == LAST_CNT);
    cnt_d          = boundary ? 8'd0 : (cnt_q + 8'd1);
    period_start_d = (cnt_d == LAST_CNT);
    accept         = cmd.cmd_valid && cmd.cmd_ready;
    cmd_sat        = (cmd.cmd_duty > DUTY_CEIL) ? DUTY_CEIL : cmd.cmd_duty;

    state_d   = state_q;
    arm_cnt_d = arm_cnt_q;
    target_d  = target_q;
    applied_d = applied_q;

    if (accept) target_d[cmd.cmd_ch] = cmd_sat;

    // The step on a boundary edge always uses the pre-edge target, even if a command lands that edge.
    if (boundary) begin
      for (int i = 0; i < 4; i++) applied_d[i] = slew_toward(applied_q[i], target_q[i]);
    end

    case (state_q)
      IDLE: begin
        target_d  = '0;
        applied_d = '0;
        if (arm) begin
          state_d   = ARMING;
          arm_cnt_d = '0;
        end
      end
      ARMING: begin
        target_d = '0;
        if (!arm) begin
          state_d = IDLE;
        end else if (boundary) begin
          if (arm_cnt_q == ARM_LAST) state_d = RUN;
          else                       arm_cnt_d = arm_cnt_q + ACW'(1);
        end
      end
      RUN: begin
        // A command accepted on the disarm edge is discarded by the forced-zero targets.
        if (!arm) begin
          state_d  = RAMPDOWN;
          target_d = '0;
        end
      end
      default: begin
        target_d = '0;
        if (boundary && (applied_d == '0)) state_d = IDLE;
      end
    endcase

    for (int i = 0; i < 4; i++) pwm_d[i] = (cnt_d < applied_d[i]);
    armed_d = (state_d == RUN);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      arm_cnt_q      <= '0;
      target_q       <= '0;
      applied_q      <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      arm_cnt_q      <= arm_cnt_d;
      target_q       <= target_d;
      applied_q      <= applied_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      armed_q        <= armed_d;
    end
  end

endmodule

// File: tb/tb_motor_throttle_sequencer.sv
// Directed scenarios plus a random command/arm phase, checked every cycle against a period-level model.
module tb_motor_throttle_sequencer;
  localparam int PERIOD      = 100;
  localparam int DUTY_MAX    = 100;
  localparam int SLEW        = 10;
  localparam int ARM_PERIODS = 8;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        arm    = 1'b0;
  logic [3:0]  pwm_out;
  logic        period_start;
  logic        armed;
  logic [1:0]  state;
  logic [31:0] duty_mon;

  motor_throttle_sequencer_if cmd_if ();

  motor_throttle_sequencer #(
    .PERIOD(PERIOD), .DUTY_MAX(DUTY_MAX), .SLEW(SLEW), .ARM_PERIODS(ARM_PERIODS)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .arm(arm), .cmd(cmd_if),
    .pwm_out(pwm_out), .period_start(period_start), .armed(armed),
    .state(state), .duty_mon(duty_mon)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  // Model: counter position, mode (0 idle,1 arming,2 run,3 rampdown), boundaries seen while arming.
  int m_cnt, m_state, m_bseen;
  int m_tgt[4];
  int m_app[4];
  int slew_exp[4];
  int ramp_exp[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_state = 0; m_bseen = 0;
    for (int i = 0; i < 4; i++) begin m_tgt[i] = 0; m_app[i] = 0; end
  endtask

  function automatic int limit_step(input int d);
    if (d > SLEW)  return SLEW;
    if (d < -SLEW) return -SLEW;
    return d;
  endfunction

  task automatic model_step();
    int nt[4];
    int na[4];
    int ns, nb, sum;
    bit bnd;
    bnd = (m_cnt == PERIOD - 1);
    ns = m_state; nb = m_bseen; sum = 0;
    for (int i = 0; i < 4; i++) begin nt[i] = m_tgt[i]; na[i] = m_app[i]; end
    if (m_state == 2 && cmd_if.cmd_valid === 1'b1)
      nt[cmd_if.cmd_ch] = (int'(cmd_if.cmd_duty) > DUTY_MAX) ? DUTY_MAX : int'(cmd_if.cmd_duty);
    if (bnd)
      for (int i = 0; i < 4; i++) na[i] = m_app[i] + limit_step(m_tgt[i] - m_app[i]);
    for (int i = 0; i < 4; i++) sum += na[i];
    case (m_state)
      0: begin
        for (int i = 0; i < 4; i++) begin nt[i] = 0; na[i] = 0; end
        if (arm) begin ns = 1; nb = 0; end
      end
      1: begin
        for (int i = 0; i < 4; i++) nt[i] = 0;
        if (!arm) ns = 0;
        else if (bnd) begin
          nb++;
          if (nb == ARM_PERIODS) ns = 2;
        end
      end
      2: if (!arm) begin
        ns = 3;
        for (int i = 0; i < 4; i++) nt[i] = 0;
      end
      default: begin
        for (int i = 0; i < 4; i++) nt[i] = 0;
        if (bnd && sum == 0) ns = 0;
      end
    endcase
    m_cnt = bnd ? 0 : m_cnt + 1;
    m_state = ns; m_bseen = nb;
    for (int i = 0; i < 4; i++) begin m_tgt[i] = nt[i]; m_app[i] = na[i]; end
  endtask

  task automatic check_outputs();
    logic [31:0] em;
    logic [3:0]  ep;
    for (int i = 0; i < 4; i++) begin
      em[8*i +: 8] = 8'(m_app[i]);
      ep[i] = (m_cnt < m_app[i]);
    end
    check("state", 32'(state), 32'(m_state));
    check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(m_state == 2));
    check("armed", 32'(armed), 32'(m_state == 2));
    check("period_start", 32'(period_start), 32'(m_cnt == PERIOD - 1));
    check("duty_mon", duty_mon, em);
    check("pwm_out", 32'(pwm_out), 32'(ep));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic run_to_boundary();
    int n = 0;
    while (period_start !== 1'b1 && n < 2 * PERIOD) begin tick(); n++; end
    check("boundary_reached", 32'(period_start), 32'd1);
  endtask

  task automatic send(input int ch, input int duty);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_ch = 2'(ch); cmd_if.cmd_duty = 8'(duty);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    int first, nb, guard, hi;
    slew_exp = '{10, 20, 30, 35};
    ramp_exp = '{30, 20, 10, 0};
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_ch = 2'd0; cmd_if.cmd_duty = 8'd0;
    model_reset();
    #12;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_mon", duty_mon, 32'd0);
    check("rst_pstart", 32'(period_start), 32'd0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);
    @(negedge clk_in);
    rst_n = 1'b1;

    first = -1;
    for (int n = 1; n <= 2 * PERIOD; n++) begin
      tick();
      if (period_start === 1'b1) begin first = n; break; end
    end
    check("first_pstart_cycle", 32'(first), 32'(PERIOD - 1));

    // Abort arming during the 4th period.
    arm = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin run_to_boundary(); tick(); end
    repeat (5) tick();
    arm = 1'b0;
    tick();
    check("abort_state", 32'(state), 32'd0);

    arm = 1'b1;
    tick();
    check("arming_state", 32'(state), 32'd1);
    nb = 0; guard = 0;
    while (state === 2'd1 && guard < (ARM_PERIODS + 2) * PERIOD) begin
      if (period_start === 1'b1) nb++;
      tick(); guard++;
    end
    check("arm_boundaries", 32'(nb), 32'(ARM_PERIODS));
    check("run_state", 32'(state), 32'd2);
    check("run_armed", 32'(armed), 32'd1);

    send(0, 35);
    for (int k = 0; k < 4; k++) begin
      run_to_boundary();
      tick();
      check("slew_applied0", 32'(duty_mon[7:0]), 32'(slew_exp[k]));
      hi = int'(pwm_out[0]);
      for (int c = 1; c < PERIOD; c++) begin tick(); hi += int'(pwm_out[0]); end
      check("slew_pwm0_high", 32'(hi), 32'(slew_exp[k]));
    end

    tick();
    send(1, 200);
    for (int k = 0; k < 10; k++) begin run_to_boundary(); tick(); end
    check("sat_applied1", 32'(duty_mon[15:8]), 32'(DUTY_MAX));
    hi = 0;
    for (int c = 0; c < PERIOD; c++) begin hi += int'(pwm_out[1]); tick(); end
    check("sat_pwm1_high", 32'(hi), 32'(PERIOD));

    run_to_boundary();
    send(3, 50);
    check("collision_same_edge", 32'(duty_mon[31:24]), 32'd0);
    run_to_boundary();
    tick();
    check("collision_next_edge", 32'(duty_mon[31:24]), 32'd10);

    send(0, 0); send(1, 0); send(3, 0); send(2, 40);
    for (int k = 0; k < 10; k++) begin run_to_boundary(); tick(); end
    check("pre_disarm_mon", duty_mon, 32'h0028_0000);
    arm = 1'b0;
    tick();
    check("rampdown_state", 32'(state), 32'd3);
    check("rampdown_ready", 32'(cmd_if.cmd_ready), 32'd0);
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_ch = 2'd2; cmd_if.cmd_duty = 8'd99;
    for (int k = 0; k < 4; k++) begin
      run_to_boundary();
      tick();
      check("ramp_applied2", 32'(duty_mon[23:16]), 32'(ramp_exp[k]));
    end
    cmd_if.cmd_valid = 1'b0;
    check("ramp_done_state", 32'(state), 32'd0);

    // Asynchronous reset while running with applied0 = 50.
    arm = 1'b1;
    tick();
    guard = 0;
    while (state !== 2'd2 && guard < (ARM_PERIODS + 2) * PERIOD) begin tick(); guard++; end
    check("rearm_run", 32'(state), 32'd2);
    send(0, 50);
    for (int k = 0; k < 5; k++) begin run_to_boundary(); tick(); end
    check("pre_reset_pwm0", 32'(pwm_out[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm_out), 32'd0);
    check("async_rst_state", 32'(state), 32'd0);
    check("async_rst_mon", duty_mon, 32'd0);
    check("async_rst_armed", 32'(armed), 32'd0);
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) arm = ~arm;
      cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_if.cmd_ch    = 2'($urandom_range(0, 3));
      cmd_if.cmd_duty  = 8'($urandom_range(0, 255));
      tick();
    end
    cmd_if.cmd_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
